// File: rtl/load_store_unit.sv
// load_store_unit: sequences word-wide data memory for RISC-V loads/stores with sub-word RMW.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors instead of rounding down.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;
  state_t r_state, w_next;
  logic        r_f3_unused_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata, r_merge, r_rdata;
  logic        r_err;
  logic        w_accept, w_err, w_misalign;
  logic [4:0]  w_bsh, w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext, w_mask, w_ins;
  assign w_accept = (r_state == IDLE) && req_valid;
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif
  assign w_err = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                 (req_we && req_funct3[2]) ||
                 ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) || w_misalign;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_err ? RESP : !req_we ? LOAD :
                                      (req_funct3 == 3'b010) ? STORE : RMW_RD;
      LOAD:    w_next = RESP;
      STORE:   w_next = RESP;
      RMW_RD:  w_next = RMW_WR;
      RMW_WR:  w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  // Half lanes use addr[1] only, so unaligned halves round down when not trapping.
  assign w_bsh  = {r_addr[1:0], 3'b000};
  assign w_hsh  = {r_addr[1], 4'b0000};
  assign w_byte = 8'(mem_rdata >> w_bsh);
  assign w_half = 16'(mem_rdata >> w_hsh);
  assign w_ext  = (r_f3 == 3'b000) ? {{24{w_byte[7]}}, w_byte} :
                  (r_f3 == 3'b100) ? {24'h0, w_byte} :
                  (r_f3 == 3'b001) ? {{16{w_half[15]}}, w_half} :
                  (r_f3 == 3'b101) ? {16'h0, w_half} : mem_rdata;
  assign w_mask = r_f3[0] ? (32'h0000FFFF << w_hsh) : (32'h000000FF << w_bsh);
  assign w_ins  = r_f3[0] ? ({16'h0, r_wdata[15:0]} << w_hsh) : ({24'h0, r_wdata[7:0]} << w_bsh);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_f3_unused_we <= 1'b0;
      r_f3           <= 3'b000;
      r_addr         <= 32'h0;
      r_wdata        <= 32'h0;
      r_merge        <= 32'h0;
      r_rdata        <= 32'h0;
      r_err          <= 1'b0;
    end else begin
      if (w_accept) begin
        r_f3_unused_we <= req_we;
        r_f3           <= req_funct3;
        r_addr         <= req_addr;
        r_wdata        <= req_wdata;
        r_rdata        <= 32'h0;
        r_err          <= w_err;
      end
      if (r_state == LOAD) r_rdata <= w_ext;
      if (r_state == RMW_RD) r_merge <= mem_rdata;
    end
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_re     = (r_state == LOAD) || (r_state == RMW_RD);
  assign mem_we     = (r_state == STORE) || (r_state == RMW_WR);
  assign mem_wdata  = (r_state == STORE) ? r_wdata :
                      (r_state == RMW_WR) ? ((r_merge & ~w_mask) | w_ins) : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random transactions against a word-array reference model.
module tb_load_store_unit;
  logic        clk = 0, rst_n = 0, tb_init = 1;
  logic        req_valid = 0, req_ready, req_we = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_err, mem_we, mem_re;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int errors = 0, checks = 0;
  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk)
    if (tb_init) for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic        exp_err;
    logic [31:0] w, b, h, exp_rd, nw;
    int          idx, bsh, hsh, exp_lat, exp_re, exp_we, cyc, nre, nwe, busy_bad;
    idx = int'(a >> 2);
    exp_err = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4) || (a >= 32'd256);
`ifdef LSU_MISALIGN_TRAP_EN
    if (((f3 == 1 || f3 == 5) && a % 2 != 0) || (f3 == 2 && a % 4 != 0)) exp_err = 1;
`endif
    w = exp_err ? 32'h0 : ref_mem[idx];
    bsh = 8 * int'(a % 4);
    hsh = 16 * int'((a / 2) % 2);
    b = (w >> bsh) & 32'hFF;
    h = (w >> hsh) & 32'hFFFF;
    exp_rd = 0;
    nw = w;
    if (!exp_err && !we)
      case (f3)
        0: exp_rd = (b >= 128) ? b + 32'hFFFFFF00 : b;
        4: exp_rd = b;
        1: exp_rd = (h >= 32768) ? h + 32'hFFFF0000 : h;
        5: exp_rd = h;
        default: exp_rd = w;
      endcase
    if (!exp_err && we)
      case (f3)
        0: nw = (w & ~(32'hFF << bsh)) | ((wd & 32'hFF) << bsh);
        1: nw = (w & ~(32'hFFFF << hsh)) | ((wd & 32'hFFFF) << hsh);
        default: nw = wd;
      endcase
    exp_lat = exp_err ? 1 : (we && f3 != 2) ? 3 : 2;
    exp_re  = exp_err ? 0 : (!we || f3 != 2) ? 1 : 0;
    exp_we  = (!exp_err && we) ? 1 : 0;
    @(negedge clk);
    chk($sformatf("ready_idle a=%h", a), 32'(req_ready), 32'd1);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 0; req_we = $urandom; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc = 0; nre = 0; nwe = 0; busy_bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_re) nre++;
      if (mem_we) nwe++;
      if (req_ready) busy_bad++;
    end while (!resp_valid && cyc < 10);
    chk($sformatf("latency we=%0d f3=%0d a=%h", we, f3, a), 32'(cyc), 32'(exp_lat));
    chk($sformatf("rdata we=%0d f3=%0d a=%h", we, f3, a), resp_rdata, exp_rd);
    chk($sformatf("err we=%0d f3=%0d a=%h", we, f3, a), 32'(resp_err), 32'(exp_err));
    chk($sformatf("re_cycles a=%h", a), 32'(nre), 32'(exp_re));
    chk($sformatf("we_cycles a=%h", a), 32'(nwe), 32'(exp_we));
    chk($sformatf("busy_not_ready a=%h", a), 32'(busy_bad), 32'd0);
    if (!exp_err && we) begin
      ref_mem[idx] = nw;
      chk($sformatf("mem[%0d]", idx), mem[idx], nw);
    end
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask
  initial begin
    int nbad;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_mwdata", mem_wdata, 32'd0);
    rst_n = 1; tb_init = 0;
    txn(0, 3'b010, 32'h14, 32'h0);
    txn(1, 3'b000, 32'h15, 32'hFFFFFFA5);
    txn(0, 3'b000, 32'h15, 32'h0);
    txn(0, 3'b100, 32'h15, 32'h0);
    txn(1, 3'b001, 32'h1A, 32'h00008001);
    txn(0, 3'b001, 32'h1A, 32'h0);
    txn(0, 3'b101, 32'h1A, 32'h0);
    txn(0, 3'b010, 32'h100, 32'h0);
    txn(0, 3'b011, 32'h10, 32'h0);
    txn(0, 3'b010, 32'h16, 32'h0);
    txn(1, 3'b100, 32'h20, 32'h1);
    txn(1, 3'b010, 32'hFC, 32'hDEADBEEF);
    txn(0, 3'b010, 32'hFC, 32'h0);
    // Reset lands while the RMW read is in flight.
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'b000; req_addr = 32'h08; req_wdata = 32'hFF;
    @(posedge clk);
    #1 req_valid = 0;
    chk("abort_in_rmw_rd", 32'(mem_re), 32'd1);
    rst_n = 0;
    #1;
    chk("abort_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    nbad = 0;
    repeat (2) begin @(negedge clk); if (mem_we) nbad++; end
    rst_n = 1;
    repeat (5) begin @(negedge clk); if (mem_we || resp_valid) nbad++; end
    chk("abort_no_we_resp", 32'(nbad), 32'd0);
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    chk("abort_mem2", mem[2], 32'h2);
    for (int k = 0; k < 60; k++)
      txn(1'($urandom), 3'($urandom),
          ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255)), $urandom);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
